// File: rtl/vending_ctrl_param_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared types and sizing helpers for the parametrised vending controller.
//   - state_t    : controller states (IDLE, COLLECT, VEND, CHANGE)
//   - creditOp_t : operation applied to the credit register each cycle
//   - sel_w()    : width of the product-select field for a product count
//   - max_credit(): largest credit value a CREDIT_W register can hold
// ---------------------------------------------------------------------------
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD       = 3'd0,
        OP_ADD        = 3'd1,
        OP_SUB_PRICE  = 3'd2,
        OP_SUB_CHANGE = 3'd3,
        OP_CLEAR      = 3'd4
    } creditOp_t;

    // A single product still needs a 1-bit select field.
    function automatic int sel_w(input int numProd);
        return (numProd > 1) ? $clog2(numProd) : 1;
    endfunction

    function automatic int max_credit(input int creditW);
        return (1 << creditW) - 1;
    endfunction

    localparam int DEFAULT_CREDIT_W = 8;
    localparam int DEFAULT_NUM_PROD = 4;
    localparam int SEL_W            = sel_w(DEFAULT_NUM_PROD);
    localparam int MAX_CREDIT       = max_credit(DEFAULT_CREDIT_W);

endpackage

// File: rtl/vending_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// vending_ctrl_param_if
// Groups the front-end strobes and the dispenser handshake of the vending
// controller.
//   master : coin acceptor / keypad / dispenser side (drives strobes, vend_ack)
//   slave  : the controller (drives vend_req, vend_id, change, status, credit)
// ---------------------------------------------------------------------------
interface vending_ctrl_param_if #(
    parameter int CREDIT_W = 8,
    parameter int COIN_W   = 4,
    parameter int SEL_W    = 2
);
    logic                coin_valid;
    logic [COIN_W-1:0]   coin_value;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel_id;
    logic                cancel;
    logic                vend_ack;
    logic                vend_req;
    logic [SEL_W-1:0]    vend_id;
    logic                change_pulse;
    logic                coin_reject;
    logic                low_credit;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin_valid, coin_value, sel_valid, sel_id, cancel, vend_ack,
        input  vend_req, vend_id, change_pulse, coin_reject, low_credit, busy, credit
    );

    modport slave (
        input  coin_valid, coin_value, sel_valid, sel_id, cancel, vend_ack,
        output vend_req, vend_id, change_pulse, coin_reject, low_credit, busy, credit
    );

endinterface

// File: rtl/vending_ctrl_param_credit_accum.sv
// ---------------------------------------------------------------------------
// credit_accum
// Credit register for the vending controller. Applies one operation per
// cycle: hold, add coin, subtract PRICE, subtract CHANGE_UNIT, or clear.
// Ports:
//   clock, reset   : system clock, asynchronous active-low reset
//   op_i           : operation to apply on the next rising edge
//   coinValue_i    : coin value in units, zero-extended internally
//   credit_o       : current credit
//   addOvf_o       : credit + coinValue_i would exceed the register range
// ---------------------------------------------------------------------------
module credit_accum
    import vending_pkg::*;
#(
    parameter int CREDIT_W    = 8,
    parameter int COIN_W      = 4,
    parameter int PRICE       = 15,
    parameter int CHANGE_UNIT = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  creditOp_t           op_i,
    input  logic [COIN_W-1:0]   coinValue_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                addOvf_o
);

    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic [CREDIT_W:0]   sumWide;

    // The add is one bit wider than the register so an overflowing coin is
    // detected rather than wrapping the credit.
    always_comb begin
        sumWide  = {1'b0, credit_q} + {1'b0, CREDIT_W'(coinValue_i)};
        addOvf_o = sumWide[CREDIT_W];
    end

    // Next credit value; the controller only requests a subtract when the
    // credit already covers it, so no underflow guard is needed here.
    always_comb begin
        credit_d = credit_q;
        unique case (op_i)
            OP_ADD:        credit_d = sumWide[CREDIT_W-1:0];
            OP_SUB_PRICE:  credit_d = credit_q - CREDIT_W'(PRICE);
            OP_SUB_CHANGE: credit_d = credit_q - CREDIT_W'(CHANGE_UNIT);
            OP_CLEAR:      credit_d = '0;
            default:       credit_d = credit_q;
        endcase
    end

    // Credit register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_o = credit_q;

endmodule

// File: rtl/vending_ctrl_param.sv
// ---------------------------------------------------------------------------
// vending_ctrl_param
// Parametrised vending controller: accumulates multi-value coins, sells any
// of NUM_PROD products at a common PRICE over a req/ack dispense handshake,
// then returns change one CHANGE_UNIT per cycle. Cancel refunds the credit.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : slave side of vending_ctrl_param_if
//            in : coin_valid, coin_value, sel_valid, sel_id, cancel, vend_ack
//            out: vend_req, vend_id, change_pulse, coin_reject, low_credit,
//                 busy, credit (all registered)
// Any credit below CHANGE_UNIT left after change is returned is forfeited.
// ---------------------------------------------------------------------------
module vending_ctrl_param
    import vending_pkg::*;
#(
    parameter int CREDIT_W    = 8,
    parameter int COIN_W      = 4,
    parameter int NUM_PROD    = 4,
    parameter int PRICE       = 15,
    parameter int CHANGE_UNIT = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    vending_ctrl_param_if.slave  bus
);

    localparam int SEL_W = sel_w(NUM_PROD);

    state_t              state_q, state_d;
    creditOp_t           creditOp;
    logic [CREDIT_W-1:0] creditNow;
    logic                addOvf;
    logic                canBuy;

    logic                vendReq_q, vendReq_d;
    logic [SEL_W-1:0]    vendId_q, vendId_d;
    logic                changePulse_q, changePulse_d;
    logic                coinReject_q, coinReject_d;
    logic                lowCredit_q, lowCredit_d;
    logic                busy_q, busy_d;

    credit_accum #(
        .CREDIT_W    (CREDIT_W),
        .COIN_W      (COIN_W),
        .PRICE       (PRICE),
        .CHANGE_UNIT (CHANGE_UNIT)
    ) u_credit (
        .clock       (clock),
        .reset       (reset),
        .op_i        (creditOp),
        .coinValue_i (bus.coin_value),
        .credit_o    (creditNow),
        .addOvf_o    (addOvf)
    );

    // An out-of-range product index is refused exactly like short credit.
    assign canBuy = (creditNow >= CREDIT_W'(PRICE)) && (32'(bus.sel_id) < NUM_PROD);

    // Next-state, credit operation and next output values.
    always_comb begin
        state_d       = state_q;
        creditOp      = OP_HOLD;
        vendReq_d     = vendReq_q;
        vendId_d      = vendId_q;
        changePulse_d = 1'b0;
        coinReject_d  = 1'b0;
        lowCredit_d   = 1'b0;

        unique case (state_q)
            IDLE, COLLECT: begin
                if (bus.cancel) begin
                    // A coin arriving alongside cancel goes straight back.
                    coinReject_d = bus.coin_valid;
                    if (creditNow != '0) begin
                        state_d = CHANGE;
                    end
                end else if (bus.sel_valid) begin
                    coinReject_d = bus.coin_valid;
                    if (canBuy) begin
                        creditOp  = OP_SUB_PRICE;
                        vendId_d  = bus.sel_id;
                        vendReq_d = 1'b1;
                        state_d   = VEND;
                    end else begin
                        lowCredit_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (addOvf || (bus.coin_value == '0)) begin
                        coinReject_d = 1'b1;
                    end else begin
                        creditOp = OP_ADD;
                        state_d  = COLLECT;
                    end
                end
            end

            VEND: begin
                coinReject_d = bus.coin_valid;
                if (bus.vend_ack) begin
                    vendReq_d = 1'b0;
                    state_d   = (creditNow != '0) ? CHANGE : IDLE;
                end
            end

            CHANGE: begin
                coinReject_d = bus.coin_valid;
                if (creditNow >= CREDIT_W'(CHANGE_UNIT)) begin
                    changePulse_d = 1'b1;
                    creditOp      = OP_SUB_CHANGE;
                end else begin
                    creditOp = OP_CLEAR;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            vendReq_q     <= 1'b0;
            vendId_q      <= '0;
            changePulse_q <= 1'b0;
            coinReject_q  <= 1'b0;
            lowCredit_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vendReq_q     <= vendReq_d;
            vendId_q      <= vendId_d;
            changePulse_q <= changePulse_d;
            coinReject_q  <= coinReject_d;
            lowCredit_q   <= lowCredit_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.vend_req     = vendReq_q;
    assign bus.vend_id      = vendId_q;
    assign bus.change_pulse = changePulse_q;
    assign bus.coin_reject  = coinReject_q;
    assign bus.low_credit   = lowCredit_q;
    assign bus.busy         = busy_q;
    assign bus.credit       = creditNow;

endmodule
